// File: rtl/uart_program_loader.sv
// Boot loader: receives a length-prefixed program over UART 8N1 and writes it into instruction memory.
// The CPU is held in reset until the load completes.
module uart_program_loader #(
  parameter int unsigned CLK_PER_BIT = 868,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned DATA_W      = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rxd,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_reset_n,
  output logic              load_done,
  output logic              load_err
);

  localparam int unsigned CNT_W = $clog2(CLK_PER_BIT);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_PER_BIT / 2 - 1);
  localparam logic [31:0]      MAX_N     = 32'(1) << ADDR_W;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {S_LEN, S_DATA, S_WRITE, S_RUN, S_ERR} ld_state_t;

  rx_state_t        r_rx_state;
  logic             r_rxd_meta;
  logic             r_rxd_sync;
  logic             r_rxd_d;
  logic [CNT_W-1:0] r_rx_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_rx_shift;
  logic             r_byte_valid;
  logic             r_frame_err;

  ld_state_t        r_state;
  logic [1:0]       r_byte_cnt;
  logic [31:0]      r_len;
  logic [DATA_W-1:0] r_word;
  logic [ADDR_W:0]  r_idx;

  logic [31:0]       w_len_next;
  logic [DATA_W-1:0] w_word_next;

  assign w_len_next  = {r_rx_shift, r_len[31:8]};
  assign w_word_next = {r_rx_shift, r_word[DATA_W-1:8]};

  // Synchroniser plus a delayed copy for falling-edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rxd_meta <= 1'b1;
      r_rxd_sync <= 1'b1;
      r_rxd_d    <= 1'b1;
    end else begin
      r_rxd_meta <= rxd;
      r_rxd_sync <= r_rxd_meta;
      r_rxd_d    <= r_rxd_sync;
    end
  end

  // Mid-bit sampling receiver; false starts are dropped at the half-bit check
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_state   <= RX_IDLE;
      r_rx_cnt     <= '0;
      r_bit_idx    <= '0;
      r_rx_shift   <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (r_rxd_d && !r_rxd_sync) begin
            r_rx_cnt   <= '0;
            r_rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (r_rx_cnt == HALF_LAST) begin
            r_rx_cnt   <= '0;
            r_bit_idx  <= '0;
            r_rx_state <= r_rxd_sync ? RX_IDLE : RX_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (r_rx_cnt == FULL_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {r_rxd_sync, r_rx_shift[7:1]};
            r_bit_idx  <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) r_rx_state <= RX_STOP;
          end else begin
            r_rx_cnt <= r_rx_cnt + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (r_rx_cnt == FULL_LAST) begin
            r_rx_cnt <= '0;
            if (r_rxd_sync) r_byte_valid <= 1'b1;
            else            r_frame_err  <= 1'b1;
            r_rx_state <= RX_IDLE;
          end else begin
            r_rx_cnt <= r_rx_cnt + CNT_W'(1);
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  // Loader: length header, then words written one per imem_we pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_LEN;
      r_byte_cnt  <= '0;
      r_len       <= '0;
      r_word      <= '0;
      r_idx       <= '0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      cpu_reset_n <= 1'b0;
      load_done   <= 1'b0;
      load_err    <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (r_state)
        S_LEN: begin
          if (r_frame_err) begin
            r_state  <= S_ERR;
            load_err <= 1'b1;
          end else if (r_byte_valid) begin
            r_len      <= w_len_next;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              if (w_len_next == 32'd0) begin
                r_state     <= S_RUN;
                load_done   <= 1'b1;
                cpu_reset_n <= 1'b1;
              end else if (w_len_next > MAX_N) begin
                r_state  <= S_ERR;
                load_err <= 1'b1;
              end else begin
                r_state <= S_DATA;
              end
            end
          end
        end
        S_DATA: begin
          if (r_frame_err) begin
            r_state  <= S_ERR;
            load_err <= 1'b1;
          end else if (r_byte_valid) begin
            r_word     <= w_word_next;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              r_state    <= S_WRITE;
              imem_we    <= 1'b1;
              imem_addr  <= r_idx[ADDR_W-1:0];
              imem_wdata <= w_word_next;
            end
          end
        end
        S_WRITE: begin
          if (r_frame_err) begin
            r_state  <= S_ERR;
            load_err <= 1'b1;
          end else begin
            r_idx <= r_idx + (ADDR_W+1)'(1);
            if (32'(r_idx) == r_len - 32'd1) begin
              r_state     <= S_RUN;
              load_done   <= 1'b1;
              cpu_reset_n <= 1'b1;
            end else begin
              r_state <= S_DATA;
            end
          end
        end
        S_RUN:   r_state <= S_RUN;
        S_ERR:   r_state <= S_ERR;
        default: r_state <= S_ERR;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader with CLK_PER_BIT=16, ADDR_W=4.
module tb_uart_program_loader;

  localparam int unsigned CPB = 16;
  localparam int unsigned AW  = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          rxd = 1'b1;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_reset_n;
  logic          load_done;
  logic          load_err;

  int checks = 0;
  int errors = 0;

  uart_program_loader #(.CLK_PER_BIT(CPB), .ADDR_W(AW), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .rxd(rxd),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset_n(cpu_reset_n), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  // Write log and timing of imem_we pulses / cpu_reset_n rises
  logic [AW-1:0] wr_addr [64];
  logic [31:0]   wr_data [64];
  int            wr_n = 0;
  int            cyc = 0;
  int            last_we_cyc = -1;
  int            rise_cyc = -1;
  logic          prev_rst = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (imem_we === 1'b1) begin
      if (wr_n < 64) begin
        wr_addr[wr_n] = imem_addr;
        wr_data[wr_n] = imem_wdata;
      end
      wr_n = wr_n + 1;
      last_we_cyc = cyc;
    end
    if (cpu_reset_n === 1'b1 && prev_rst !== 1'b1) rise_cyc = cyc;
    prev_rst = cpu_reset_n;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rxd = 1'b1;
    reset_n = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_body(input logic [7:0] b);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_body(b);
    rxd = stop;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(8'(w >> (8 * i)), 1'b1);
  endtask

  int base;

  initial begin
    // Reset state
    do_reset();
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_cpu", 32'(cpu_reset_n), 32'd0);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_err", 32'(load_err), 32'd0);

    // N=2 normal load
    base = wr_n;
    send_word(32'd2);
    send_word(32'h0000_0013);
    send_word(32'hDEAD_BEEF);
    repeat (5) @(negedge clk);
    chk("n2_count", 32'(wr_n - base), 32'd2);
    chk("n2_addr0", 32'(wr_addr[base]), 32'd0);
    chk("n2_data0", wr_data[base], 32'h0000_0013);
    chk("n2_addr1", 32'(wr_addr[base+1]), 32'd1);
    chk("n2_data1", wr_data[base+1], 32'hDEAD_BEEF);
    chk("n2_rise_lat", 32'(rise_cyc - last_we_cyc), 32'd1);
    chk("n2_cpu", 32'(cpu_reset_n), 32'd1);
    chk("n2_done", 32'(load_done), 32'd1);
    chk("n2_err", 32'(load_err), 32'd0);
    chk("n2_hold_addr", 32'(imem_addr), 32'd1);
    chk("n2_hold_data", imem_wdata, 32'hDEAD_BEEF);
    send_word(32'h1234_5678);
    chk("n2_ignore", 32'(wr_n - base), 32'd2);

    // N=0: release right after the 4th header byte
    do_reset();
    base = wr_n;
    for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b1);
    send_body(8'h00);
    chk("n0_cpu_before", 32'(cpu_reset_n), 32'd0);
    chk("n0_done_before", 32'(load_done), 32'd0);
    rxd = 1'b1;
    repeat (CPB) @(negedge clk);
    chk("n0_cpu", 32'(cpu_reset_n), 32'd1);
    chk("n0_done", 32'(load_done), 32'd1);
    chk("n0_err", 32'(load_err), 32'd0);
    chk("n0_writes", 32'(wr_n - base), 32'd0);

    // N=17 overflow
    do_reset();
    base = wr_n;
    send_word(32'd17);
    repeat (5) @(negedge clk);
    chk("n17_err", 32'(load_err), 32'd1);
    chk("n17_done", 32'(load_done), 32'd0);
    chk("n17_cpu", 32'(cpu_reset_n), 32'd0);
    send_word(32'h1122_3344);
    chk("n17_writes", 32'(wr_n - base), 32'd0);
    chk("n17_cpu_late", 32'(cpu_reset_n), 32'd0);

    // Short low glitch followed by N=1 load
    do_reset();
    base = wr_n;
    rxd = 1'b0;
    repeat (6) @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    send_word(32'd1);
    send_word(32'hA5A5_A5A5);
    repeat (5) @(negedge clk);
    chk("gl_count", 32'(wr_n - base), 32'd1);
    chk("gl_addr", 32'(wr_addr[base]), 32'd0);
    chk("gl_data", wr_data[base], 32'hA5A5_A5A5);
    chk("gl_done", 32'(load_done), 32'd1);
    chk("gl_err", 32'(load_err), 32'd0);

    // Framing error on the second data byte
    do_reset();
    base = wr_n;
    send_word(32'd1);
    send_byte(8'hEF, 1'b1);
    send_byte(8'hBE, 1'b0);
    send_byte(8'hAD, 1'b1);
    send_byte(8'hDE, 1'b1);
    repeat (5) @(negedge clk);
    chk("fe_err", 32'(load_err), 32'd1);
    chk("fe_done", 32'(load_done), 32'd0);
    chk("fe_cpu", 32'(cpu_reset_n), 32'd0);
    chk("fe_writes", 32'(wr_n - base), 32'd0);

    // Reset midway through word 1 of an N=3 load, then full rerun
    do_reset();
    base = wr_n;
    send_word(32'd3);
    send_word(32'h0000_0010);
    send_byte(8'h20, 1'b1);
    send_byte(8'h00, 1'b1);
    chk("mr_pre_writes", 32'(wr_n - base), 32'd1);
    chk("mr_pre_wdata", imem_wdata, 32'h0000_0010);
    #3 reset_n = 1'b0;
    #1;
    chk("mr_we", 32'(imem_we), 32'd0);
    chk("mr_wdata", imem_wdata, 32'd0);
    chk("mr_cpu", 32'(cpu_reset_n), 32'd0);
    chk("mr_done", 32'(load_done), 32'd0);
    chk("mr_err", 32'(load_err), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    base = wr_n;
    send_word(32'd3);
    send_word(32'h0000_0100);
    send_word(32'h0000_0200);
    send_word(32'h0000_0300);
    repeat (5) @(negedge clk);
    chk("mr_count", 32'(wr_n - base), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("mr_addr", 32'(wr_addr[base+i]), 32'(i));
      chk("mr_data", wr_data[base+i], 32'(256 * (i + 1)));
    end
    chk("mr_done2", 32'(load_done), 32'd1);
    chk("mr_cpu2", 32'(cpu_reset_n), 32'd1);

    // N=16 fills memory exactly
    do_reset();
    base = wr_n;
    send_word(32'd16);
    for (int i = 0; i < 16; i++) send_word(32'hC0DE_0000 + 32'(i));
    repeat (5) @(negedge clk);
    chk("full_count", 32'(wr_n - base), 32'd16);
    chk("full_last_addr", 32'(wr_addr[base+15]), 32'd15);
    chk("full_last_data", wr_data[base+15], 32'hC0DE_000F);
    chk("full_first_data", wr_data[base], 32'hC0DE_0000);
    chk("full_done", 32'(load_done), 32'd1);
    chk("full_err", 32'(load_err), 32'd0);
    chk("full_cpu", 32'(cpu_reset_n), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
